// File: rtl/rom_rr_arbiter_if.sv
// Requester and shared-ROM handshake bundle for rom_rr_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface rom_rr_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_addr_valid;
  logic              r0_addr_ready;
  logic [DATA_W-1:0] r0_data;
  logic              r0_data_valid;
  logic              r0_data_ready;

  logic [ADDR_W-1:0] r1_addr;
  logic              r1_addr_valid;
  logic              r1_addr_ready;
  logic [DATA_W-1:0] r1_data;
  logic              r1_data_valid;
  logic              r1_data_ready;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_addr_valid;
  logic              rom_addr_ready;
  logic [DATA_W-1:0] rom_data;
  logic              rom_data_valid;
  logic              rom_data_ready;

  modport slave (
    input  r0_addr, r0_addr_valid, r0_data_ready,
    input  r1_addr, r1_addr_valid, r1_data_ready,
    input  rom_addr_ready, rom_data, rom_data_valid,
    output r0_addr_ready, r0_data, r0_data_valid,
    output r1_addr_ready, r1_data, r1_data_valid,
    output rom_addr, rom_addr_valid, rom_data_ready
  );

  modport master (
    output r0_addr, r0_addr_valid, r0_data_ready,
    output r1_addr, r1_addr_valid, r1_data_ready,
    output rom_addr_ready, rom_data, rom_data_valid,
    input  r0_addr_ready, r0_data, r0_data_valid,
    input  r1_addr_ready, r1_data, r1_data_valid,
    input  rom_addr, rom_addr_valid, rom_data_ready
  );
endinterface

// File: rtl/rom_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port parameter ROM,
// one outstanding transaction, response steered back to the granted requester.
module rom_rr_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  rom_rr_arbiter_if.slave bus,
  output logic            gnt_id,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, GRANT, ROM_REQ, ROM_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic [1:0]        addr_ready_q, addr_ready_d;
  logic [1:0]        data_valid_q, data_valid_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_addr_valid_q, rom_addr_valid_d;
  logic              rom_data_ready_q, rom_data_ready_d;

  logic [1:0]        req;
  logic              gnt_addr_valid;
  logic              gnt_data_ready;
  logic [ADDR_W-1:0] gnt_addr;

  assign req            = {bus.r1_addr_valid, bus.r0_addr_valid};
  assign gnt_addr_valid = gnt_q ? bus.r1_addr_valid : bus.r0_addr_valid;
  assign gnt_data_ready = gnt_q ? bus.r1_data_ready : bus.r0_data_ready;
  assign gnt_addr       = gnt_q ? bus.r1_addr       : bus.r0_addr;

  // Every output is computed as its next-cycle value here and taken straight from a flop.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    last_d           = last_q;
    addr_ready_d     = '0;
    data_valid_d     = data_valid_q;
    data0_d          = data0_q;
    data1_d          = data1_q;
    rom_addr_d       = rom_addr_q;
    rom_addr_valid_d = rom_addr_valid_q;
    rom_data_ready_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d        = (req == 2'b11) ? ~last_q : req[1];
          addr_ready_d = gnt_d ? 2'b10 : 2'b01;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // A requester that withdrew its valid leaves the pointer untouched.
        if (gnt_addr_valid) begin
          rom_addr_d       = gnt_addr;
          rom_addr_valid_d = 1'b1;
          state_d          = ROM_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      ROM_REQ: begin
        if (bus.rom_addr_ready) begin
          rom_addr_valid_d = 1'b0;
          state_d          = ROM_WAIT;
        end
      end
      ROM_WAIT: begin
        if (bus.rom_data_valid) begin
          if (gnt_q) data1_d = bus.rom_data;
          else       data0_d = bus.rom_data;
          data_valid_d     = gnt_q ? 2'b10 : 2'b01;
          rom_data_ready_d = 1'b1;
          state_d          = RESP;
        end
      end
      RESP: begin
        if (gnt_data_ready) begin
          data_valid_d = '0;
          last_d       = gnt_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      gnt_q            <= 1'b0;
      last_q           <= 1'b1;
      busy_q           <= 1'b0;
      addr_ready_q     <= '0;
      data_valid_q     <= '0;
      data0_q          <= '0;
      data1_q          <= '0;
      rom_addr_q       <= '0;
      rom_addr_valid_q <= 1'b0;
      rom_data_ready_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      last_q           <= last_d;
      busy_q           <= busy_d;
      addr_ready_q     <= addr_ready_d;
      data_valid_q     <= data_valid_d;
      data0_q          <= data0_d;
      data1_q          <= data1_d;
      rom_addr_q       <= rom_addr_d;
      rom_addr_valid_q <= rom_addr_valid_d;
      rom_data_ready_q <= rom_data_ready_d;
    end
  end

  assign bus.r0_addr_ready  = addr_ready_q[0];
  assign bus.r1_addr_ready  = addr_ready_q[1];
  assign bus.r0_data_valid  = data_valid_q[0];
  assign bus.r1_data_valid  = data_valid_q[1];
  assign bus.r0_data        = data0_q;
  assign bus.r1_data        = data1_q;
  assign bus.rom_addr       = rom_addr_q;
  assign bus.rom_addr_valid = rom_addr_valid_q;
  assign bus.rom_data_ready = rom_data_ready_q;
  assign gnt_id             = gnt_q;
  assign busy               = busy_q;

endmodule
